// File: rtl/reg_wr_arbiter_4mb.sv
// Two-requester (SPI / aux) arbiter for the register-bank write port, with idle gap and aux window.
// Optional macro REG_ARB_RR_EN: round-robin collision resolution (default build: SPI always wins).
module reg_wr_arbiter_4mb #(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter logic [15:0] AUX_ADDR_MIN = 16'h0000,
  parameter logic [15:0] AUX_ADDR_MAX = 16'h00FF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_100m,
  input  logic             rst_n_syn,
  input  logic             spi_wr_req,
  input  logic [15:0]      spi_addr,
  input  logic [31:0]      spi_data,
  output logic             spi_wr_ack,
  input  logic             aux_wr_req,
  input  logic [15:0]      aux_addr,
  input  logic [31:0]      aux_data,
  output logic             aux_wr_ack,
  output logic             aux_wr_err,
  output logic [31:0]      data_mosi,
  output logic [15:0]      addr,
  output logic             data_mosi_rdy,
  output logic [CNT_W-1:0] coll_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_A = 2'd1;
  localparam logic [1:0] ST_GRANT_B = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);
  localparam bit         NO_GAP   = (GAP_CYCLES == 32'd0);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       gap_cnt;
  logic [3:0]       gap_nxt;
  logic             eval;
  logic             any_req;
  logic             both_req;
  logic             pick_b;
  logic             aux_in_win;
  logic             rdy_nxt;
  logic             spi_ack_nxt;
  logic             aux_ack_nxt;
  logic             aux_err_nxt;
  logic [31:0]      data_nxt;
  logic [15:0]      addr_nxt;
  logic [CNT_W-1:0] coll_nxt;

  // Unsigned inclusive window test done with borrow bits so a zero lower bound never folds to a constant compare.
  function automatic logic in_window(input logic [15:0] a);
    logic [16:0] lo_diff;
    logic [16:0] hi_diff;
    lo_diff = {1'b0, a} - {1'b0, AUX_ADDR_MIN};
    hi_diff = {1'b0, AUX_ADDR_MAX} - {1'b0, a};
    return ~lo_diff[16] & ~hi_diff[16];
  endfunction

  assign any_req    = spi_wr_req | aux_wr_req;
  assign both_req   = spi_wr_req & aux_wr_req;
  assign aux_in_win = in_window(aux_addr);

`ifdef REG_ARB_RR_EN
  logic last_b;

  // On a collision the requester that was not granted last wins.
  assign pick_b = aux_wr_req & (~spi_wr_req | ~last_b);

  // Round-robin pointer: remembers which side took the most recent grant (ack or err).
  always_ff @(posedge clk_100m) begin
    if (!rst_n_syn) begin
      last_b <= 1'b0;
    end else if (eval && any_req) begin
      last_b <= pick_b;
    end else begin
      last_b <= last_b;
    end
  end
`else
  assign pick_b = aux_wr_req & ~spi_wr_req;
`endif

  // Arbitration happens in IDLE, on the last GAP cycle, or straight out of a grant when no gap is configured.
  always_comb begin
    case (state)
      ST_IDLE:                eval = 1'b1;
      ST_GRANT_A, ST_GRANT_B: eval = NO_GAP;
      ST_GAP:                 eval = (gap_cnt <= 4'd1);
      default:                eval = 1'b0;
    endcase
  end

  // Next state, gap counter and the registered write-port / handshake values.
  always_comb begin
    state_nxt   = state;
    gap_nxt     = gap_cnt;
    rdy_nxt     = 1'b0;
    spi_ack_nxt = 1'b0;
    aux_ack_nxt = 1'b0;
    aux_err_nxt = 1'b0;
    data_nxt    = data_mosi;
    addr_nxt    = addr;
    coll_nxt    = coll_cnt;
    if (eval) begin
      if (any_req) begin
        state_nxt = pick_b ? ST_GRANT_B : ST_GRANT_A;
        gap_nxt   = 4'd0;
        if (both_req && !(&coll_cnt)) begin
          coll_nxt = coll_cnt + CNT_W'(1'b1);
        end else begin
          coll_nxt = coll_cnt;
        end
        if (!pick_b) begin
          rdy_nxt     = 1'b1;
          spi_ack_nxt = 1'b1;
          data_nxt    = spi_data;
          addr_nxt    = spi_addr;
        end else if (aux_in_win) begin
          rdy_nxt     = 1'b1;
          aux_ack_nxt = 1'b1;
          data_nxt    = aux_data;
          addr_nxt    = aux_addr;
        end else begin
          // Rejected aux write: the bank port keeps its previous address/data.
          aux_err_nxt = 1'b1;
        end
      end else begin
        state_nxt = ST_IDLE;
        gap_nxt   = 4'd0;
      end
    end else begin
      case (state)
        ST_GRANT_A, ST_GRANT_B: begin
          state_nxt = ST_GAP;
          gap_nxt   = GAP_LOAD;
        end
        ST_GAP: begin
          state_nxt = ST_GAP;
          gap_nxt   = gap_cnt - 4'd1;
        end
        default: begin
          state_nxt = ST_IDLE;
          gap_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State and output registers; a reset abandons any grant in flight.
  always_ff @(posedge clk_100m) begin
    if (!rst_n_syn) begin
      state         <= ST_IDLE;
      gap_cnt       <= 4'd0;
      data_mosi_rdy <= 1'b0;
      spi_wr_ack    <= 1'b0;
      aux_wr_ack    <= 1'b0;
      aux_wr_err    <= 1'b0;
      data_mosi     <= 32'h0000_0000;
      addr          <= 16'h0000;
      coll_cnt      <= {CNT_W{1'b0}};
    end else begin
      state         <= state_nxt;
      gap_cnt       <= gap_nxt;
      data_mosi_rdy <= rdy_nxt;
      spi_wr_ack    <= spi_ack_nxt;
      aux_wr_ack    <= aux_ack_nxt;
      aux_wr_err    <= aux_err_nxt;
      data_mosi     <= data_nxt;
      addr          <= addr_nxt;
      coll_cnt      <= coll_nxt;
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter_4mb.sv
// Self-checking bench for reg_wr_arbiter_4mb: directed test-plan cases plus randomized traffic
// compared every cycle against a cooldown/queue-style behavioural model (second DUT uses CNT_W=2).
module tb_reg_wr_arbiter_4mb;

  localparam int GAP  = 2;
  localparam int AMIN = 0;
  localparam int AMAX = 255;
`ifdef REG_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  logic        rst_n_syn  = 1'b0;
  logic        spi_wr_req = 1'b0;
  logic [15:0] spi_addr   = 16'h0000;
  logic [31:0] spi_data   = 32'h0000_0000;
  logic        aux_wr_req = 1'b0;
  logic [15:0] aux_addr   = 16'h0000;
  logic [31:0] aux_data   = 32'h0000_0000;

  logic        spi_wr_ack, aux_wr_ack, aux_wr_err, data_mosi_rdy;
  logic [31:0] data_mosi;
  logic [15:0] addr;
  logic [15:0] coll_cnt;
  logic        sat_spi_ack, sat_aux_ack, sat_aux_err, sat_rdy;
  logic [31:0] sat_data;
  logic [15:0] sat_addr;
  logic [1:0]  sat_coll;

  reg_wr_arbiter_4mb dut (
    .clk_100m(clk_100m), .rst_n_syn(rst_n_syn),
    .spi_wr_req(spi_wr_req), .spi_addr(spi_addr), .spi_data(spi_data), .spi_wr_ack(spi_wr_ack),
    .aux_wr_req(aux_wr_req), .aux_addr(aux_addr), .aux_data(aux_data),
    .aux_wr_ack(aux_wr_ack), .aux_wr_err(aux_wr_err),
    .data_mosi(data_mosi), .addr(addr), .data_mosi_rdy(data_mosi_rdy), .coll_cnt(coll_cnt)
  );

  reg_wr_arbiter_4mb #(.CNT_W(2)) dut_sat (
    .clk_100m(clk_100m), .rst_n_syn(rst_n_syn),
    .spi_wr_req(spi_wr_req), .spi_addr(spi_addr), .spi_data(spi_data), .spi_wr_ack(sat_spi_ack),
    .aux_wr_req(aux_wr_req), .aux_addr(aux_addr), .aux_data(aux_data),
    .aux_wr_ack(sat_aux_ack), .aux_wr_err(sat_aux_err),
    .data_mosi(sat_data), .addr(sat_addr), .data_mosi_rdy(sat_rdy), .coll_cnt(sat_coll)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: after a decision, the next decision may happen GAP+1 edges later.
  int          m_wait   = 0;
  longint      m_coll   = 0;
  bit          m_last_b = 1'b0;
  bit          m_rdy = 1'b0, m_sack = 1'b0, m_aack = 1'b0, m_err = 1'b0;
  logic [31:0] m_data = 32'h0;
  logic [15:0] m_addr = 16'h0;

  task automatic model_step();
    bit pick_b;
    if (!rst_n_syn) begin
      m_wait = 0; m_coll = 0; m_last_b = 1'b0;
      m_rdy = 1'b0; m_sack = 1'b0; m_aack = 1'b0; m_err = 1'b0;
      m_data = 32'h0; m_addr = 16'h0;
    end else begin
      m_rdy = 1'b0; m_sack = 1'b0; m_aack = 1'b0; m_err = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
      end else if (spi_wr_req || aux_wr_req) begin
        if (spi_wr_req && aux_wr_req) m_coll++;
        pick_b = aux_wr_req && (!spi_wr_req || (RR && !m_last_b));
        if (!pick_b) begin
          m_rdy = 1'b1; m_sack = 1'b1; m_addr = spi_addr; m_data = spi_data;
        end else if (int'(aux_addr) >= AMIN && int'(aux_addr) <= AMAX) begin
          m_rdy = 1'b1; m_aack = 1'b1; m_addr = aux_addr; m_data = aux_data;
        end else begin
          m_err = 1'b1;
        end
        m_last_b = pick_b;
        m_wait = GAP;
      end
    end
  endtask

  always @(posedge clk_100m) begin
    logic [63:0] e16, e2;
    model_step();
    e16 = (m_coll > 65535) ? 64'd65535 : 64'(m_coll);
    e2  = (m_coll > 3) ? 64'd3 : 64'(m_coll);
    #1;
    check("rdy",      64'(data_mosi_rdy), 64'(m_rdy));
    check("spi_ack",  64'(spi_wr_ack),    64'(m_sack));
    check("aux_ack",  64'(aux_wr_ack),    64'(m_aack));
    check("aux_err",  64'(aux_wr_err),    64'(m_err));
    check("addr",     64'(addr),          64'(m_addr));
    check("data",     64'(data_mosi),     64'(m_data));
    check("coll",     64'(coll_cnt),      e16);
    check("sat_rdy",  64'(sat_rdy),       64'(m_rdy));
    check("sat_ack",  64'({sat_spi_ack, sat_aux_ack, sat_aux_err}), 64'({m_sack, m_aack, m_err}));
    check("sat_addr", 64'({sat_addr, sat_data}), 64'({m_addr, m_data}));
    check("sat_coll", 64'(sat_coll),      e2);
  end

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic pick_aux_addr();
    case ($urandom_range(5))
      0: aux_addr = 16'h0000;
      1: aux_addr = 16'h00FF;
      2: aux_addr = 16'h0100;
      3: aux_addr = 16'hFFFF;
      4: aux_addr = 16'($urandom_range(255));
      default: aux_addr = 16'($urandom);
    endcase
  endtask

  initial begin
    bit a_hold, b_hold;
    int grants;
    bit seq[$];
    a_hold = 1'b0; b_hold = 1'b0;
    repeat (3) @(negedge clk_100m);

    // Plan 1: single SPI write after reset release
    rst_n_syn = 1'b1; spi_wr_req = 1'b1; spi_addr = 16'h0010; spi_data = 32'h0000_0055;
    tick();
    check("t1_rdy",  64'(data_mosi_rdy), 64'd1);
    check("t1_ack",  64'(spi_wr_ack),    64'd1);
    check("t1_addr", 64'(addr),          64'h10);
    check("t1_data", 64'(data_mosi),     64'h55);
    check("t1_coll", 64'(coll_cnt),      64'd0);
    @(negedge clk_100m);
    tick();
    check("t1_rdy_low", 64'(data_mosi_rdy), 64'd0);
    @(negedge clk_100m); spi_wr_req = 1'b0;
    tick();

    // Plan 2: aux out of window -> err, bank port untouched
    @(negedge clk_100m); aux_wr_req = 1'b1; aux_addr = 16'h0100; aux_data = 32'hDEAD_BEEF;
    tick();
    check("t2_err",  64'(aux_wr_err),    64'd1);
    check("t2_ack",  64'(aux_wr_ack),    64'd0);
    check("t2_rdy",  64'(data_mosi_rdy), 64'd0);
    check("t2_addr", 64'(addr),          64'h10);
    check("t2_data", 64'(data_mosi),     64'h55);
    @(negedge clk_100m);
    tick();
    @(negedge clk_100m); aux_wr_req = 1'b0; rst_n_syn = 1'b0;
    tick();

    // Plan 3: simultaneous requests from a fresh reset
    @(negedge clk_100m);
    rst_n_syn = 1'b1;
    spi_wr_req = 1'b1; spi_addr = 16'h0020; spi_data = 32'h0000_000A;
    aux_wr_req = 1'b1; aux_addr = 16'h0030; aux_data = 32'h0000_000B;
    tick();
    check("t3_first_addr", 64'(addr), RR ? 64'h30 : 64'h20);
    check("t3_first_ack",  64'({spi_wr_ack, aux_wr_ack}), RR ? 64'b01 : 64'b10);
    check("t3_coll",       64'(coll_cnt), 64'd1);
    @(negedge clk_100m);
    tick();
    @(negedge clk_100m);
    if (RR) aux_wr_req = 1'b0; else spi_wr_req = 1'b0;
    tick();
    tick();
    check("t3_second_addr", 64'(addr), RR ? 64'h20 : 64'h30);
    check("t3_second_ack",  64'({spi_wr_ack, aux_wr_ack}), RR ? 64'b10 : 64'b01);
    check("t3_coll_hold",   64'(coll_cnt), 64'd1);
    @(negedge clk_100m);
    tick();
    @(negedge clk_100m); spi_wr_req = 1'b0; aux_wr_req = 1'b0;
    repeat (3) tick();

    // Plan 6: reset during GRANT_A, held request restarts afterwards
    @(negedge clk_100m); spi_wr_req = 1'b1; spi_addr = 16'h0040; spi_data = 32'h0000_0077;
    tick();
    check("t6_grant", 64'(data_mosi_rdy), 64'd1);
    @(negedge clk_100m); rst_n_syn = 1'b0;
    tick();
    check("t6_rst_outs", 64'({data_mosi_rdy, spi_wr_ack, aux_wr_ack, aux_wr_err}), 64'd0);
    check("t6_rst_port", 64'({addr, data_mosi}), 64'd0);
    check("t6_rst_coll", 64'(coll_cnt), 64'd0);
    @(negedge clk_100m); rst_n_syn = 1'b1;
    tick();
    check("t6_restart_rdy",  64'(data_mosi_rdy), 64'd1);
    check("t6_restart_addr", 64'(addr),          64'h40);
    @(negedge clk_100m);
    tick();

    // Plans 4/5: continuous collisions for 10 grants; CNT_W=2 copy must stick at 3
    @(negedge clk_100m); rst_n_syn = 1'b0; spi_wr_req = 1'b0; aux_wr_req = 1'b0;
    @(negedge clk_100m);
    rst_n_syn = 1'b1; spi_wr_req = 1'b1; aux_wr_req = 1'b1;
    aux_addr = 16'h0011; aux_data = 32'h1111_0000; spi_addr = 16'h0022; spi_data = 32'h2222_0000;
    grants = 0;
    for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
      @(negedge clk_100m);
      if (spi_wr_ack) begin
        seq.push_back(1'b0); grants++; a_hold = 1'b1;
      end else if (a_hold) begin
        a_hold = 1'b0; spi_addr = 16'($urandom); spi_data = $urandom;
      end
      if (aux_wr_ack || aux_wr_err) begin
        seq.push_back(1'b1); grants++; b_hold = 1'b1;
      end else if (b_hold) begin
        b_hold = 1'b0; aux_addr = 16'($urandom_range(255)); aux_data = $urandom;
      end
    end
    check("t4_grants", 64'(grants), 64'd10);
    check("t4_coll",   64'(coll_cnt), 64'd10);
    check("t5_sat",    64'(sat_coll), 64'd3);
    for (int i = 0; i < seq.size(); i++) begin
      check($sformatf("t4_order_%0d", i), 64'(seq[i]), RR ? 64'(i % 2 == 0) : 64'd0);
    end
    spi_wr_req = 1'b0; aux_wr_req = 1'b0; a_hold = 1'b0; b_hold = 1'b0;
    repeat (4) @(negedge clk_100m);

    // Randomized traffic with occasional resets; the compare process does the checking
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_100m);
      rst_n_syn = ($urandom_range(299) != 0);
      if (spi_wr_ack) begin
        a_hold = 1'b1;
      end else if (a_hold || !spi_wr_req) begin
        a_hold = 1'b0;
        spi_wr_req = ($urandom_range(99) < 45);
        spi_addr = 16'($urandom); spi_data = $urandom;
      end
      if (aux_wr_ack || aux_wr_err) begin
        b_hold = 1'b1;
      end else if (b_hold || !aux_wr_req) begin
        b_hold = 1'b0;
        aux_wr_req = ($urandom_range(99) < 45);
        pick_aux_addr(); aux_data = $urandom;
      end
    end
    @(negedge clk_100m); spi_wr_req = 1'b0; aux_wr_req = 1'b0; rst_n_syn = 1'b1;
    repeat (6) @(negedge clk_100m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
